// File: rtl/output_uart_tx_pkg.sv
// Shared FSM encodings, bit-count width and parity helper for the output UART.
// The PARITY encoding exists only when OUT_UART_PARITY_EN is defined.
package output_uart_tx_pkg;

  localparam int BitCntW = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef OUT_UART_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/output_uart_tx_if.sv
// CPU-side output port bundle: write strobe and word in, serial line and status out.
// master = CPU/bench side, slave = UART side.
interface output_uart_tx_if #(
  parameter int DataWidth = 16
);
  logic                 Out_Ld;
  logic [DataWidth-1:0] Out_Data;
  logic                 Tx;
  logic                 Busy;
  logic                 Full;
  logic                 Overflow;

  modport master (output Out_Ld, Out_Data, input Tx, Busy, Full, Overflow);
  modport slave  (input Out_Ld, Out_Data, output Tx, Busy, Full, Overflow);
endinterface

// File: rtl/output_uart_tx_sync_fifo.sv
// Show-ahead synchronous FIFO; write lands 1 cycle after Push, DOut is the head combinationally.
// Push while Full is dropped unless Pop in the same cycle frees the slot.
module sync_fifo #(
  parameter int DataWidth = 16,
  parameter int FifoDepth = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Push,
  input  logic                 Pop,
  input  logic [DataWidth-1:0] DIn,
  output logic [DataWidth-1:0] DOut,
  output logic                 Empty,
  output logic                 Full
);
  localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW = PtrW + 1;

  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 wr_en, rd_en;

  assign Empty = (count_q == '0);
  assign Full  = (count_q == CntW'(FifoDepth));
  assign DOut  = mem_q[rd_ptr_q];

  // A same-cycle pop makes room, so a push on a full FIFO still lands.
  assign wr_en = Push & (~Full | Pop);
  assign rd_en = Pop & ~Empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(wr_en);
    rd_ptr_d = rd_ptr_q + PtrW'(rd_en);
    count_d  = count_q + CntW'(wr_en) - CntW'(rd_en);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= DIn;
  end
endmodule

// File: rtl/output_uart_tx.sv
// Buffers CPU output words and sends each as two UART bytes (low first), 8N1 or 8E1 with OUT_UART_PARITY_EN.
// Tx falls one edge after a word is captured into an empty FIFO; writes to a full FIFO are dropped and flag Overflow.
module output_uart_tx
  import output_uart_tx_pkg::*;
#(
  parameter int DataWidth  = 16,
  parameter int FifoDepth  = 4,
  parameter int ClksPerBit = 868
) (
  input  logic              Clk,
  input  logic              Reset,
  output_uart_tx_if.slave   bus
);
  localparam int BaudW = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam logic [BaudW-1:0] BaudLast = BaudW'(ClksPerBit - 1);

  state_e               state_q, state_d;
  logic [BaudW-1:0]     baud_q, baud_d;
  logic [BitCntW-1:0]   bit_q, bit_d;
  logic [7:0]           shift_q, shift_d;
  logic [DataWidth-1:0] hold_q, hold_d;
  logic                 byte_sel_q, byte_sel_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q, ovf_d;

  logic                 fifo_pop, fifo_empty, fifo_full;
  logic [DataWidth-1:0] fifo_dout;
  logic                 baud_tc;
  logic [7:0]           cur_byte;

  sync_fifo #(.DataWidth(DataWidth), .FifoDepth(FifoDepth)) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .Push  (bus.Out_Ld),
    .Pop   (fifo_pop),
    .DIn   (bus.Out_Data),
    .DOut  (fifo_dout),
    .Empty (fifo_empty),
    .Full  (fifo_full)
  );

  assign baud_tc  = (baud_q == BaudLast);
  assign cur_byte = byte_sel_q ? hold_q[15:8] : hold_q[7:0];

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    byte_sel_d = byte_sel_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;
    ovf_d      = ovf_q | (bus.Out_Ld & fifo_full & ~fifo_pop);

    if (state_q != ST_IDLE) baud_d = baud_tc ? '0 : baud_q + BaudW'(1);

    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          hold_d     = fifo_dout;
          byte_sel_d = 1'b0;
          bit_d      = '0;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end
      end
      ST_START: if (baud_tc) begin
        // Shift reg takes the selected byte as the start bit ends.
        shift_d = cur_byte;
        tx_d    = cur_byte[0];
        state_d = ST_DATA;
      end
      ST_DATA: if (baud_tc) begin
        shift_d = {shift_q[0], shift_q[7:1]};
        if (bit_q == BitCntW'(7)) begin
          bit_d = '0;
`ifdef OUT_UART_PARITY_EN
          tx_d    = even_parity(cur_byte);
          state_d = ST_PARITY;
`else
          tx_d    = 1'b1;
          state_d = ST_STOP;
`endif
        end else begin
          bit_d = bit_q + BitCntW'(1);
          tx_d  = shift_q[1];
        end
      end
`ifdef OUT_UART_PARITY_EN
      ST_PARITY: if (baud_tc) begin
        tx_d    = 1'b1;
        state_d = ST_STOP;
      end
`endif
      ST_STOP: if (baud_tc) begin
        if (!byte_sel_q) begin
          byte_sel_d = 1'b1;
          tx_d       = 1'b0;
          state_d    = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Recomputed with the final pop so a pop-freed slot is never flagged.
    ovf_d = ovf_q | (bus.Out_Ld & fifo_full & ~fifo_pop);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      byte_sel_q <= 1'b0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      byte_sel_q <= byte_sel_d;
      tx_q       <= tx_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.Tx       = tx_q;
  assign bus.Busy     = (state_q != ST_IDLE) | ~fifo_empty;
  assign bus.Full     = fifo_full;
  assign bus.Overflow = ovf_q;
endmodule
